// File: rtl/rv64_gpr_scoreboard.sv
// RV64 GPR scoreboard: one saturating-free outstanding-write counter per register,
// gates issue on RAW hazards and counter capacity, with same-cycle writeback bypass.
module rv64_gpr_scoreboard #(
  parameter int REG_NUM       = 32,
  parameter int REG_ADDRWIDTH = 5,
  parameter int CNT_W         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [REG_ADDRWIDTH-1:0] issue_rs1_idx_i,
  input  logic [REG_ADDRWIDTH-1:0] issue_rs2_idx_i,
  input  logic                     issue_rs1_ren_i,
  input  logic                     issue_rs2_ren_i,
  input  logic [REG_ADDRWIDTH-1:0] issue_rd_idx_i,
  input  logic                     issue_rd_wen_i,
  input  logic                     wb_valid_i,
  input  logic [REG_ADDRWIDTH-1:0] wb_idx_i,
  input  logic                     flush_i,
  output logic [REG_NUM-1:0]       busy_vec_o,
  output logic                     err_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [REG_NUM];
  logic [CNT_W-1:0] cnt_d [REG_NUM];
  logic             err_q;
  logic             err_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic             rs1_haz, rs2_haz, rd_full;
  logic             fire, inc_any, dec_any, wb_err;
  logic [REG_NUM-1:0] inc_vec, dec_vec;

  assign rs1_cnt = cnt_q[issue_rs1_idx_i];
  assign rs2_cnt = cnt_q[issue_rs2_idx_i];
  assign rd_cnt  = cnt_q[issue_rd_idx_i];
  assign wb_cnt  = cnt_q[wb_idx_i];

  // A source whose last outstanding write retires this cycle is forwarded by the regfile.
  assign rs1_haz = issue_rs1_ren_i && (issue_rs1_idx_i != '0) && (rs1_cnt != '0) &&
                   !(wb_valid_i && (wb_idx_i == issue_rs1_idx_i) && (rs1_cnt == CntOne));
  assign rs2_haz = issue_rs2_ren_i && (issue_rs2_idx_i != '0) && (rs2_cnt != '0) &&
                   !(wb_valid_i && (wb_idx_i == issue_rs2_idx_i) && (rs2_cnt == CntOne));
  assign rd_full = issue_rd_wen_i && (issue_rd_idx_i != '0) && (rd_cnt == CntMax) &&
                   !(wb_valid_i && (wb_idx_i == issue_rd_idx_i));

  assign issue_ready_o = !rs1_haz && !rs2_haz && !rd_full && !flush_i && !rst;
  assign fire          = issue_valid_i && issue_ready_o;
  assign inc_any       = fire && issue_rd_wen_i && (issue_rd_idx_i != '0);
  assign dec_any       = wb_valid_i && (wb_idx_i != '0) && (wb_cnt != '0);
  assign wb_err        = wb_valid_i && (wb_idx_i != '0) && (wb_cnt == '0) &&
                         !(inc_any && (issue_rd_idx_i == wb_idx_i));
  assign err_d         = err_q || wb_err;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      inc_vec[i] = inc_any && (issue_rd_idx_i == REG_ADDRWIDTH'(i));
      dec_vec[i] = dec_any && (wb_idx_i == REG_ADDRWIDTH'(i));
    end
  end

  // A simultaneous inc and dec on one register cancel; flush wipes everything.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      if (flush_i || (i == 0)) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_vec_o = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      busy_vec_o[i] = (cnt_q[i] != '0);
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_rv64_gpr_scoreboard.sv
// Directed bench for rv64_gpr_scoreboard: a per-register outstanding-write model is checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_rv64_gpr_scoreboard;

  localparam int N    = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid_i;
  logic          issue_ready_o;
  logic [AW-1:0] issue_rs1_idx_i, issue_rs2_idx_i, issue_rd_idx_i, wb_idx_i;
  logic          issue_rs1_ren_i, issue_rs2_ren_i, issue_rd_wen_i;
  logic          wb_valid_i;
  logic          flush_i;
  logic [N-1:0]  busy_vec_o;
  logic          err_o;

  rv64_gpr_scoreboard #(.REG_NUM(N), .REG_ADDRWIDTH(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_rs1_idx_i(issue_rs1_idx_i),
    .issue_rs2_idx_i(issue_rs2_idx_i),
    .issue_rs1_ren_i(issue_rs1_ren_i),
    .issue_rs2_ren_i(issue_rs2_ren_i),
    .issue_rd_idx_i (issue_rd_idx_i),
    .issue_rd_wen_i (issue_rd_wen_i),
    .wb_valid_i     (wb_valid_i),
    .wb_idx_i       (wb_idx_i),
    .flush_i        (flush_i),
    .busy_vec_o     (busy_vec_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int           modelCnt [N];
  bit           modelErr = 1'b0;
  bit           checkEn = 1'b0;
  int           nChecks = 0;
  int           nFails = 0;
  bit           mFire, mInc, mDec;
  logic [N-1:0] expBusy;

  // Reference rules: how many writes each register still owes, and what may issue.
  function automatic bit srcBlocked(bit ren, int idx);
    if (!ren || idx == 0 || modelCnt[idx] == 0) return 1'b0;
    if (wb_valid_i && int'(wb_idx_i) == idx && modelCnt[idx] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit modelReady();
    int rd;
    rd = int'(issue_rd_idx_i);
    if (rst || flush_i) return 1'b0;
    if (srcBlocked(issue_rs1_ren_i, int'(issue_rs1_idx_i))) return 1'b0;
    if (srcBlocked(issue_rs2_ren_i, int'(issue_rs2_idx_i))) return 1'b0;
    if (issue_rd_wen_i && rd != 0 && modelCnt[rd] == MAXC &&
        !(wb_valid_i && int'(wb_idx_i) == rd)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) modelCnt[i] = 0;
      modelErr = 1'b0;
      checkEn  = 1'b1;
    end else begin
      mFire = issue_valid_i && modelReady();
      mInc  = mFire && issue_rd_wen_i && issue_rd_idx_i != 0;
      mDec  = wb_valid_i && wb_idx_i != 0 && modelCnt[wb_idx_i] != 0;
      if (wb_valid_i && wb_idx_i != 0 && modelCnt[wb_idx_i] == 0 &&
          !(mInc && issue_rd_idx_i == wb_idx_i)) modelErr = 1'b1;
      if (flush_i) begin
        for (int i = 0; i < N; i++) modelCnt[i] = 0;
      end else begin
        if (mDec) modelCnt[wb_idx_i] = modelCnt[wb_idx_i] - 1;
        if (mInc) modelCnt[issue_rd_idx_i] = modelCnt[issue_rd_idx_i] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < N; i++) expBusy[i] = (modelCnt[i] != 0);
      checkOutput("model_ready", 64'(issue_ready_o), 64'(modelReady()));
      checkOutput("model_busy", 64'(busy_vec_o), 64'(expBusy));
      checkOutput("model_err", 64'(err_o), 64'(modelErr));
    end
  end

  // One call is one clock cycle; returns at the following negedge.
  task automatic applyStimulus(input bit v, input int rs1, input bit r1, input int rs2, input bit r2,
                               input int rd, input bit wen, input bit wbv, input int wbi,
                               input bit fl, input bit rs);
    @(posedge clk);
    #1;
    issue_valid_i   = v;
    issue_rs1_idx_i = AW'(rs1);
    issue_rs1_ren_i = r1;
    issue_rs2_idx_i = AW'(rs2);
    issue_rs2_ren_i = r2;
    issue_rd_idx_i  = AW'(rd);
    issue_rd_wen_i  = wen;
    wb_valid_i      = wbv;
    wb_idx_i        = AW'(wbi);
    flush_i         = fl;
    rst             = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueRd(input int rd);
    applyStimulus(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0);
  endtask

  task automatic doWb(input int idx);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, idx, 0, 0);
  endtask

  initial begin
    rst = 1'b1; issue_valid_i = 0; issue_rs1_idx_i = 0; issue_rs2_idx_i = 0;
    issue_rs1_ren_i = 0; issue_rs2_ren_i = 0; issue_rd_idx_i = 0; issue_rd_wen_i = 0;
    wb_valid_i = 0; wb_idx_i = 0; flush_i = 0;

    // Reset with activity on every input
    applyStimulus(1, 5, 1, 0, 0, 5, 1, 1, 5, 0, 1);
    checkOutput("rst_ready", 64'(issue_ready_o), 64'd0);
    idle();
    checkOutput("rst_busy", 64'(busy_vec_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);

    // RAW on x5 with same-cycle writeback bypass
    issueRd(5);
    checkOutput("raw_issue_ready", 64'(issue_ready_o), 64'd1);
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_busy5", 64'(busy_vec_o[5]), 64'd1);
    checkOutput("raw_stall", 64'(issue_ready_o), 64'd0);
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    checkOutput("raw_bypass_ready", 64'(issue_ready_o), 64'd1);
    idle();
    checkOutput("raw_busy5_clear", 64'(busy_vec_o[5]), 64'd0);

    // Fill x7 to capacity
    issueRd(7); issueRd(7); issueRd(7);
    issueRd(7);
    checkOutput("full_stall", 64'(issue_ready_o), 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    checkOutput("full_wb_accept", 64'(issue_ready_o), 64'd1);
    idle();
    checkOutput("full_still_busy", 64'(busy_vec_o[7]), 64'd1);
    doWb(7); doWb(7);
    checkOutput("full_drain_busy", 64'(busy_vec_o[7]), 64'd1);
    doWb(7);
    idle();
    checkOutput("full_drained", 64'(busy_vec_o[7]), 64'd0);

    // Simultaneous inc/dec on x9 with count 1
    issueRd(9);
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0);
    idle();
    checkOutput("incdec_busy9", 64'(busy_vec_o[9]), 64'd1);
    doWb(9);
    idle();
    checkOutput("incdec_busy9_clear", 64'(busy_vec_o[9]), 64'd0);

    // x0 is never tracked
    applyStimulus(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    checkOutput("x0_ready", 64'(issue_ready_o), 64'd1);
    idle();
    checkOutput("x0_busy", 64'(busy_vec_o), 64'd0);
    checkOutput("x0_err", 64'(err_o), 64'd0);

    // rs2 hazard, read-enable gating, and no bypass while two writes remain
    issueRd(12);
    applyStimulus(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("rs2_stall", 64'(issue_ready_o), 64'd0);
    applyStimulus(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs2_ren_off", 64'(issue_ready_o), 64'd1);
    issueRd(13); issueRd(13);
    applyStimulus(1, 13, 1, 0, 0, 0, 0, 1, 13, 0, 0);
    checkOutput("cnt2_no_bypass", 64'(issue_ready_o), 64'd0);
    doWb(12); doWb(13);
    idle();
    checkOutput("drain_busy", 64'(busy_vec_o), 64'd0);

    // Flush overrides issue; err is sticky through flush
    issueRd(3); issueRd(4);
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0);
    checkOutput("flush_ready", 64'(issue_ready_o), 64'd0);
    idle();
    checkOutput("flush_busy", 64'(busy_vec_o), 64'd0);
    doWb(3);
    checkOutput("err_not_yet", 64'(err_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("err_set", 64'(err_o), 64'd1);
    idle();
    checkOutput("err_sticky_flush", 64'(err_o), 64'd1);

    // Mid-stream reset
    issueRd(10); issueRd(10);
    applyStimulus(1, 0, 0, 0, 0, 10, 1, 1, 10, 0, 1);
    checkOutput("midrst_ready", 64'(issue_ready_o), 64'd0);
    idle();
    checkOutput("midrst_busy", 64'(busy_vec_o), 64'd0);
    checkOutput("midrst_err", 64'(err_o), 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
